// File: rtl/reactor_pkg.sv
// Shared definitions for the reactor sensor scheduler and its helpers.
//   DATA_W       : sample / average width
//   SUM_W        : accumulator width for four samples (never overflows)
//   TEMP_LIMIT   : over-temperature set threshold
//   TEMP_HYST    : hysteresis band below TEMP_LIMIT before the flag clears
//   NUM_CH, CH_W : channel count and channel index width
//   FAULT_SAMPLE : fail-hot value substituted for a timed-out channel
package reactor_pkg;

    localparam int unsigned DATA_W     = 9;
    localparam int unsigned SUM_W      = DATA_W + 2;
    localparam int unsigned TEMP_LIMIT = 300;
    localparam int unsigned TEMP_HYST  = 10;
    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned CH_W       = 2;

    localparam logic [DATA_W-1:0] FAULT_SAMPLE = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        EVAL
    } schedState_e;

endpackage

// File: rtl/reactor_sensor_scheduler_if.sv
// Shared-ADC request/acknowledge bus.
//   adc_req  : sample request (master -> ADC)
//   adc_ch   : channel select, valid while adc_req=1 (master -> ADC)
//   adc_ack  : data valid, qualifies adc_data (ADC -> master)
//   adc_data : sample from the selected channel (ADC -> master)
interface reactor_sensor_scheduler_if;

    logic                             adc_req;
    logic [reactor_pkg::CH_W-1:0]     adc_ch;
    logic                             adc_ack;
    logic [reactor_pkg::DATA_W-1:0]   adc_data;

    modport master (
        output adc_req,
        output adc_ch,
        input  adc_ack,
        input  adc_data
    );

    modport slave (
        input  adc_req,
        input  adc_ch,
        output adc_ack,
        output adc_data
    );

endinterface

// File: rtl/temp_hysteresis.sv
// Hysteretic over-temperature flag, reusable for any temperature monitor.
//   CLOCK    : clock, rising edge
//   reset    : synchronous active-high reset (flag clears)
//   update   : strobe; avg is evaluated only when high
//   avg      : averaged temperature
//   overTemp : sets at avg >= LIMIT, clears at avg < LIMIT - HYST, else holds
module temp_hysteresis #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned LIMIT = 300,
    parameter int unsigned HYST  = 10
) (
    input  logic             CLOCK,
    input  logic             reset,
    input  logic             update,
    input  logic [WIDTH-1:0] avg,
    output logic             overTemp
);

    localparam logic [WIDTH-1:0] SET_LEVEL = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] CLR_LEVEL = WIDTH'(LIMIT - HYST);

    logic hotQ, hotD;

    always_comb begin
        hotD = hotQ;
        if (update) begin
            if (avg >= SET_LEVEL) begin
                hotD = 1'b1;
            end else if (avg < CLR_LEVEL) begin
                hotD = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            hotQ <= 1'b0;
        end else begin
            hotQ <= hotD;
        end
    end

    assign overTemp = hotQ;

endmodule

// File: rtl/reactor_sensor_scheduler.sv
// Round-robin sweep of the four reactor temperature channels through one shared
// ADC; publishes the average of each sweep and a hysteretic over-temp flag.
//   CLOCK     : clock, rising edge
//   reset     : synchronous active-high reset; aborts any sweep in progress
//   enable    : permits new sweeps to start
//   adc       : shared ADC req/ack bus (master side)
//   avg_temp  : last computed average
//   avg_valid : one-cycle pulse when avg_temp updates
//   over_temp : hysteretic over-temperature flag
//   busy      : high while a sweep is in progress
//   ch_fault  : sticky per-channel timeout flags
// Optional build macro SENSOR_TIMEOUT_EN: bounds the ack wait to TIMEOUT cycles,
// substitutes FAULT_SAMPLE and flags the channel. Without it ch_fault is 0.
module reactor_sensor_scheduler
    import reactor_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 16
`ifdef SENSOR_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 8
`endif
) (
    input  logic                       CLOCK,
    input  logic                       reset,
    input  logic                       enable,
    reactor_sensor_scheduler_if.master adc,
    output logic [DATA_W-1:0]          avg_temp,
    output logic                       avg_valid,
    output logic                       over_temp,
    output logic                       busy,
    output logic [NUM_CH-1:0]          ch_fault
);

    localparam int unsigned       IDLE_W    = $clog2(SAMPLE_PERIOD);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SAMPLE_PERIOD - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

    schedState_e       stateQ, stateD;
    logic [IDLE_W-1:0] idleCntQ, idleCntD;
    logic [SUM_W-1:0]  sumQ, sumD;
    logic [CH_W-1:0]   chQ, chD;
    logic              reqQ, reqD;
    logic              busyQ, busyD;
    logic              validQ, validD;
    logic [DATA_W-1:0] avgQ, avgD;
    logic [DATA_W-1:0] sample;
    logic              take;

`ifdef SENSOR_TIMEOUT_EN
    localparam int unsigned       WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] waitCntQ, waitCntD;
    logic [NUM_CH-1:0] faultQ, faultD;
`endif

    always_comb begin
        stateD   = stateQ;
        idleCntD = idleCntQ;
        sumD     = sumQ;
        chD      = chQ;
        reqD     = reqQ;
        busyD    = busyQ;
        avgD     = avgQ;
        validD   = 1'b0;
        sample   = adc.adc_data;
        take     = 1'b0;
`ifdef SENSOR_TIMEOUT_EN
        // Counter only advances while a request is outstanding without ack.
        waitCntD = '0;
        faultD   = faultQ;
`endif
        unique case (stateQ)
            IDLE: begin
                if (enable) begin
                    if (idleCntQ == IDLE_LAST) begin
                        idleCntD = '0;
                        sumD     = '0;
                        chD      = '0;
                        reqD     = 1'b1;
                        busyD    = 1'b1;
                        stateD   = REQ;
                    end else begin
                        idleCntD = idleCntQ + 1'b1;
                    end
                end
            end
            REQ: begin
                // reqQ low here is the mandatory gap cycle between channels.
                if (!reqQ) begin
                    reqD = 1'b1;
                end else if (adc.adc_ack) begin
                    take = 1'b1;
`ifdef SENSOR_TIMEOUT_EN
                end else if (waitCntQ == WAIT_LAST) begin
                    take        = 1'b1;
                    sample      = FAULT_SAMPLE;
                    faultD[chQ] = 1'b1;
                end else begin
                    waitCntD = waitCntQ + 1'b1;
`endif
                end
                if (take) begin
                    sumD = sumQ + SUM_W'(sample);
                    reqD = 1'b0;
                    if (chQ == LAST_CH) begin
                        stateD = EVAL;
                    end else begin
                        chD = chQ + 1'b1;
                    end
                end
            end
            EVAL: begin
                avgD   = sumQ[SUM_W-1:2];
                validD = 1'b1;
                busyD  = 1'b0;
                chD    = '0;
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            stateQ   <= IDLE;
            idleCntQ <= '0;
            sumQ     <= '0;
            chQ      <= '0;
            reqQ     <= 1'b0;
            busyQ    <= 1'b0;
            validQ   <= 1'b0;
            avgQ     <= '0;
        end else begin
            stateQ   <= stateD;
            idleCntQ <= idleCntD;
            sumQ     <= sumD;
            chQ      <= chD;
            reqQ     <= reqD;
            busyQ    <= busyD;
            validQ   <= validD;
            avgQ     <= avgD;
        end
    end

`ifdef SENSOR_TIMEOUT_EN
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            waitCntQ <= '0;
            faultQ   <= '0;
        end else begin
            waitCntQ <= waitCntD;
            faultQ   <= faultD;
        end
    end

    assign ch_fault = faultQ;
`else
    assign ch_fault = '0;
`endif

    // Flag updates on the same edge as avg_temp, from the same truncated sum.
    temp_hysteresis #(
        .WIDTH (DATA_W),
        .LIMIT (TEMP_LIMIT),
        .HYST  (TEMP_HYST)
    ) uHyst (
        .CLOCK    (CLOCK),
        .reset    (reset),
        .update   (stateQ == EVAL),
        .avg      (sumQ[SUM_W-1:2]),
        .overTemp (over_temp)
    );

    assign adc.adc_req = reqQ;
    assign adc.adc_ch  = chQ;
    assign avg_temp    = avgQ;
    assign avg_valid   = validQ;
    assign busy        = busyQ;

endmodule
